// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - unified byte-maskable memory shared by instruction and data ports
// Two request/valid ports arbitrated round-robin into one array with LATENCY-cycle response.

module mem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int LATENCY    = 1,
   parameter int DATA_FIRST = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                p0_request,
   input  logic                p0_we_re,
   input  logic [DATA_W/8-1:0] p0_masking,
   input  logic [ADDR_W-1:0]   p0_address,
   input  logic [DATA_W-1:0]   p0_w_data,
   output logic                p0_valid,
   output logic [DATA_W-1:0]   p0_r_data,
   input  logic                p1_request,
   input  logic                p1_we_re,
   input  logic [DATA_W/8-1:0] p1_masking,
   input  logic [ADDR_W-1:0]   p1_address,
   input  logic [DATA_W-1:0]   p1_w_data,
   output logic                p1_valid,
   output logic [DATA_W-1:0]   p1_r_data
);

   localparam int         NB       = DATA_W / 8;
   localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state_q;
   logic [2:0]          cnt_q;
   logic                gnt_q;
   logic                we_q;
   logic                last_grant_q;
   logic [DATA_W-1:0]   buf_q;
   logic                p0_valid_q, p1_valid_q;
   logic [DATA_W-1:0]   p0_r_data_q, p1_r_data_q;
   logic [DATA_W-1:0]   mem_q [0:(1<<ADDR_W)-1];

   logic                grant_sel;
   logic                accept;
   logic                sel_we;
   logic [NB-1:0]       sel_mask;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W-1:0]   rd_word;
   logic                enter_resp;
   logic                resp_port;
   logic                resp_rd;
   logic [DATA_W-1:0]   resp_data;

   // Under contention the port that lost last time wins; otherwise whoever asks.
   always_comb begin
      grant_sel = p1_request;
      if (p0_request && p1_request) begin
         grant_sel = ~last_grant_q;
      end
   end

   assign accept    = (state_q == IDLE) && (p0_request || p1_request);
   assign sel_we    = grant_sel ? p1_we_re   : p0_we_re;
   assign sel_mask  = grant_sel ? p1_masking : p0_masking;
   assign sel_addr  = grant_sel ? p1_address : p0_address;
   assign sel_wdata = grant_sel ? p1_w_data  : p0_w_data;
   assign rd_word   = mem_q[sel_addr];

   always_ff @(posedge clk) begin
      if (accept && sel_we) begin
         for (int i = 0; i < NB; i++) begin
            if (sel_mask[i]) begin
               mem_q[sel_addr][8*i +: 8] <= sel_wdata[8*i +: 8];
            end
         end
      end
   end

   // The response is loaded on the edge that enters RESP, so valid/r_data come straight from flops.
   always_comb begin
      enter_resp = 1'b0;
      resp_port  = gnt_q;
      resp_rd    = ~we_q;
      resp_data  = buf_q;
      if (state_q == IDLE) begin
         enter_resp = accept && (LATENCY == 1);
         resp_port  = grant_sel;
         resp_rd    = ~sel_we;
         resp_data  = rd_word;
      end else if (state_q == WAIT) begin
         enter_resp = (cnt_q == 3'd1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         gnt_q        <= 1'b0;
         we_q         <= 1'b0;
         last_grant_q <= (DATA_FIRST != 0) ? 1'b0 : 1'b1;
         buf_q        <= '0;
         p0_valid_q   <= 1'b0;
         p1_valid_q   <= 1'b0;
         p0_r_data_q  <= '0;
         p1_r_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  gnt_q        <= grant_sel;
                  last_grant_q <= grant_sel;
                  we_q         <= sel_we;
                  if (!sel_we) begin
                     buf_q <= rd_word;
                  end
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 3'd1) begin
                  state_q <= RESP;
                  cnt_q   <= 3'd0;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= 3'd0;
            end
         endcase

         p0_valid_q <= enter_resp && !resp_port;
         p1_valid_q <= enter_resp &&  resp_port;
         if (enter_resp && resp_rd && !resp_port) begin
            p0_r_data_q <= resp_data;
         end
         if (enter_resp && resp_rd && resp_port) begin
            p1_r_data_q <= resp_data;
         end
      end
   end

   assign p0_valid  = p0_valid_q;
   assign p1_valid  = p1_valid_q;
   assign p0_r_data = p0_r_data_q;
   assign p1_r_data = p1_r_data_q;

endmodule
